sync_fifo_gen: RTL
==================

# sync_fifo_gen

Parametrised single-clock FIFO for fabric-side buffering. It generalises the fixed-geometry 36Kb FIFO primitive to any data width, any power-of-two depth, and either standard or first-word-fall-through (FWFT) read mode. It adds an occupancy count output and guarded pointers: rejected accesses never corrupt state. Storage is an inferred register/RAM array with a registered read port.

## Interface
- DATA_WIDTH, 36: word width, 1–256.
- DEPTH, 1024: entries; power of two, 4–65536.
- FWFT, 0: 0 = standard read mode, 1 = first-word-fall-through.
- PROG_EMPTY_THRESH, 4: PROG_EMPTY asserts when COUNT <= this value.
- PROG_FULL_THRESH, DEPTH-4: PROG_FULL asserts when COUNT >= this value.

Ports (AW = $clog2(DEPTH)):
- CLK  input  1  clock; all logic on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- WR_EN  input  1  write request.
- WR_DATA  input  DATA_WIDTH  write data.
- RD_EN  input  1  read request (FWFT: pop/acknowledge).
- CLR_ERR  input  1  clears sticky error flags; used only with SYNC_FIFO_GEN_STICKY_ERR_EN.
- RD_DATA  output  DATA_WIDTH  read data.
- COUNT  output  AW+1  words held, including the FWFT output word.
- EMPTY, ALMOST_EMPTY, FULL, ALMOST_FULL, PROG_EMPTY, PROG_FULL  output  1 each  status flags.
- OVERFLOW, UNDERFLOW  output  1 each  error flags.

## Operation
- Write accepted = WR_EN && !FULL. Read accepted = RD_EN && !EMPTY. Each flag is evaluated before the edge.
- Rejected write: no pointer, memory or COUNT change; OVERFLOW is raised.
- Rejected read: no state change; RD_DATA holds; UNDERFLOW is raised.
- Pointers are AW bits and wrap DEPTH-1 → 0. COUNT changes by +1, -1, or 0 (accepted read and write in the same cycle).
- Flag definitions:
  - EMPTY = (COUNT==0); in FWFT mode, EMPTY = no valid output word.
  - FULL = (COUNT==DEPTH).
  - ALMOST_EMPTY = (COUNT==1).
  - ALMOST_FULL = (COUNT==DEPTH-1).
  - PROG_* use the thresholds above.
- All flags are registered from the post-edge COUNT, so they update on the same edge as COUNT.
- Standard mode: an accepted read loads the head word into RD_DATA on that edge.
- FWFT mode:
  - A one-word output register holds the head word.
  - An accepted read pops it; the next word, if any, is loaded on the same edge.
  - RD_DATA is valid whenever EMPTY=0.
- Reset values: RD_DATA=0, COUNT=0, pointers=0, EMPTY=1, PROG_EMPTY=1, all other flags 0.
- Reset is asynchronous; RESET mid-operation discards all contents immediately. Memory contents are not cleared but are unreachable.

## Timing
- Standard mode, write to empty FIFO at edge N: EMPTY=0 and COUNT=1 after edge N. RD_EN at edge N+1 gives RD_DATA after edge N+1.
- FWFT mode, write to empty FIFO at edge N: COUNT=1 after edge N. The output register loads at edge N+1, and EMPTY falls after edge N+1.
- FWFT mode, an accepted write at edge N lands in the output register at edge N+1 when the FIFO holds no other words. This applies whether the output register was already empty or was emptied by a pop at edge N.
- Simultaneous accepted read and write at COUNT==DEPTH-1 or 1: COUNT unchanged; flags unchanged.
- WR_EN while FULL: rejected even with a simultaneous accepted read.
- RD_EN while EMPTY: rejected even with a simultaneous accepted write.

## Configuration
- SYNC_FIFO_GEN_STICKY_ERR_EN defined:
  - OVERFLOW and UNDERFLOW are sticky from the edge after the offending request.
  - They clear at the edge where CLR_ERR=1, or on RESET.
  - If a new error and CLR_ERR coincide, the flag stays set.
- Macro undefined:
  - OVERFLOW and UNDERFLOW are one-cycle pulses, high for the cycle after each rejected request.
  - CLR_ERR is ignored.

## Test plan
- DEPTH=16, DATA_WIDTH=8, FWFT=0: write 0x00..0x0F.
  - FULL=1 and COUNT=16 after the 16th edge; ALMOST_FULL=1 after the 15th.
  - Read all 16 back in order 0x00..0x0F; EMPTY=1 after the last read.
- Full FIFO, WR_EN=1 and RD_EN=1 for one cycle: write rejected, read accepted.
  - COUNT=15, OVERFLOW=1 for one cycle (macro off).
  - The next read returns 0x01, not the rejected word.
- FWFT=1: write 0xA5 at edge N.
  - EMPTY=0 and RD_DATA=0xA5 after edge N+1.
  - RD_EN pops it: EMPTY=1, COUNT=0.
- Wrap-around: 40 continuous write+read pairs at COUNT=3 on DEPTH=16.
  - Data order is preserved and COUNT stays 3 throughout.
  - PROG_EMPTY=1 with threshold 4.
- RD_EN on empty FIFO with macro defined: UNDERFLOW=1 and held for 10 cycles; CLR_ERR pulse clears it the edge after.
- Assert RESET asynchronously at COUNT=9, between edges.
  - COUNT=0, EMPTY=1 and PROG_EMPTY=1 immediately, with no clock.
  - After release, first write/read returns the new data.

Source files
------------

// File: rtl/sync_fifo_gen.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through read mode.
// Define SYNC_FIFO_GEN_STICKY_ERR_EN to make OVERFLOW/UNDERFLOW sticky until CLR_ERR.
module sync_fifo_gen #(
    parameter int unsigned DATA_WIDTH        = 36,
    parameter int unsigned DEPTH             = 1024,
    parameter int unsigned FWFT              = 0,
    parameter int unsigned PROG_EMPTY_THRESH = 4,
    parameter int unsigned PROG_FULL_THRESH  = DEPTH - 4,
    localparam int unsigned AW               = $clog2(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  WR_EN,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  RD_EN,
    input  logic                  CLR_ERR,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic [AW:0]           COUNT,
    output logic                  EMPTY,
    output logic                  ALMOST_EMPTY,
    output logic                  FULL,
    output logic                  ALMOST_FULL,
    output logic                  PROG_EMPTY,
    output logic                  PROG_FULL,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_AF   = (AW + 1)'(DEPTH - 1);
    localparam logic [AW:0]   CNT_PE   = (AW + 1)'(PROG_EMPTY_THRESH);
    localparam logic [AW:0]   CNT_PF   = (AW + 1)'(PROG_FULL_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [AW:0]           count_q, count_d, mem_count;
    logic                  valid_q, valid_d;
    logic                  wr_acc, rd_acc, mem_rd;
    logic                  empty_q, empty_d;
    logic                  aempty_q, full_q, afull_q, pempty_q, pfull_q;
    logic                  ovf_q, ovf_d, udf_q, udf_d;

    always_comb begin
        wr_acc    = WR_EN && !full_q;
        rd_acc    = RD_EN && !empty_q;
        // Words still in the array; in FWFT mode the output register holds one more.
        mem_count = count_q - {{AW{1'b0}}, valid_q};
        if (FWFT != 0) begin
            mem_rd  = (mem_count != '0) && (!valid_q || rd_acc);
            valid_d = mem_rd || (valid_q && !rd_acc);
        end else begin
            mem_rd  = rd_acc;
            valid_d = 1'b0;
        end

        count_d = count_q;
        if (wr_acc && !rd_acc) begin
            count_d = count_q + CNT_ONE;
        end else if (!wr_acc && rd_acc) begin
            count_d = count_q - CNT_ONE;
        end

        empty_d = (FWFT != 0) ? !valid_d : (count_d == '0);

`ifdef SYNC_FIFO_GEN_STICKY_ERR_EN
        // A coincident new error wins over CLR_ERR.
        ovf_d = (WR_EN && full_q) || (ovf_q && !CLR_ERR);
        udf_d = (RD_EN && empty_q) || (udf_q && !CLR_ERR);
`else
        ovf_d = WR_EN && full_q;
        udf_d = RD_EN && empty_q;
`endif
    end

`ifndef SYNC_FIFO_GEN_STICKY_ERR_EN
    logic unused_clr_err;
    assign unused_clr_err = CLR_ERR;
`endif

    always_ff @(posedge CLK) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= WR_DATA;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rd_data_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            empty_q   <= 1'b1;
            aempty_q  <= 1'b0;
            full_q    <= 1'b0;
            afull_q   <= 1'b0;
            pempty_q  <= 1'b1;
            pfull_q   <= 1'b0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            if (mem_rd) begin
                rd_data_q <= mem[rd_ptr_q];
                rd_ptr_q  <= rd_ptr_q + PTR_ONE;
            end
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            count_q  <= count_d;
            valid_q  <= valid_d;
            empty_q  <= empty_d;
            aempty_q <= (count_d == CNT_ONE);
            full_q   <= (count_d == CNT_FULL);
            afull_q  <= (count_d == CNT_AF);
            pempty_q <= (count_d <= CNT_PE);
            pfull_q  <= (count_d >= CNT_PF);
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    assign RD_DATA      = rd_data_q;
    assign COUNT        = count_q;
    assign EMPTY        = empty_q;
    assign ALMOST_EMPTY = aempty_q;
    assign FULL         = full_q;
    assign ALMOST_FULL  = afull_q;
    assign PROG_EMPTY   = pempty_q;
    assign PROG_FULL    = pfull_q;
    assign OVERFLOW     = ovf_q;
    assign UNDERFLOW    = udf_q;

endmodule
